// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter types, encodings and FIFO sizing.
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
  typedef enum logic [1:0] {WLEN_5 = 2'b00, WLEN_6 = 2'b01, WLEN_7 = 2'b10, WLEN_8 = 2'b11} wlen_e;
  localparam int UART_TX_FIFO_DEPTH = 16;
  localparam int UART_TX_PTR_W = 4;
  function automatic logic [7:0] wlen_mask(input logic [1:0] w);
    return 8'hFF >> (2'd3 - w);
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 16x8 synchronous transmit FIFO with flush; single_i limits it to one entry.
module uart_tx_fifo import uart_pkg::*; (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  logic       single_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam logic [UART_TX_PTR_W:0] DEPTH_N = (UART_TX_PTR_W+1)'(UART_TX_FIFO_DEPTH);
  logic [7:0] mem_q [UART_TX_FIFO_DEPTH];
  logic [UART_TX_PTR_W-1:0] wr_q, rd_q;
  logic [UART_TX_PTR_W:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_pop = pop_i & ~empty_o;
  // a pop frees the slot, so a write to a full FIFO in the same cycle is accepted
  assign do_push = push_i & (~full_o | do_pop);
  assign cnt_d = flush_i ? '0 : cnt_q + (UART_TX_PTR_W+1)'(do_push) - (UART_TX_PTR_W+1)'(do_pop);
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      full_o <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      wr_q <= flush_i ? '0 : wr_q + UART_TX_PTR_W'(do_push);
      rd_q <= flush_i ? '0 : rd_q + UART_TX_PTR_W'(do_pop);
      cnt_q <= cnt_d;
      full_o <= cnt_d == (single_i ? (UART_TX_PTR_W+1)'(1) : DEPTH_N);
      empty_o <= cnt_d == '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with FIFO, configurable frame format, break and abort.
module uart_tx import uart_pkg::*; (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       Baud16,
  input  logic       En,
  input  logic       TxEn,
  input  logic [1:0] WLEN,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       STP2,
  input  logic       BRK,
  input  logic       FEN,
  input  logic [7:0] TxData,
  input  logic       TxWrite,
  output logic       TxFull,
  output logic       TxEmpty,
  output logic       Busy,
  output logic       TXD
);
  tx_state_e state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, fifo_dout;
  logic [1:0] wlen_q, wlen_d;
  logic pen_q, pen_d, eps_q, eps_d, stp2_q, stp2_d, par_q, par_d;
  logic txd_q, txd_d, fen_q;
  logic empty, full, go, bit_end, last_data, start;
  uart_tx_fifo u_fifo (
    .CLK(CLK),
    .RESETn(RESETn),
    .push_i(TxWrite),
    .pop_i(start),
    .flush_i(FEN != fen_q),
    .single_i(~FEN),
    .din_i(TxData),
    .dout_o(fifo_dout),
    .full_o(full),
    .empty_o(empty)
  );
  assign go = Baud16 & En & TxEn & ~empty;
  assign bit_end = Baud16 & (tick_q == 4'd15);
  assign last_data = bit_q == {1'b0, wlen_q} + 3'd4;
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    sh_d = sh_q;
    wlen_d = wlen_q;
    pen_d = pen_q;
    eps_d = eps_q;
    stp2_d = stp2_q;
    par_d = par_q;
    start = 1'b0;
    // the tick counter wraps 15->0 on the pulse that ends a bit
    if (state_q != ST_IDLE && Baud16) tick_d = tick_q + 4'd1;
    unique case (state_q)
      ST_IDLE: start = go;
      ST_START: state_d = bit_end ? ST_DATA : ST_START;
      ST_DATA: if (bit_end) begin
        sh_d = sh_q >> 1;
        bit_d = last_data ? 3'd0 : bit_q + 3'd1;
        state_d = !last_data ? ST_DATA : pen_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_d = bit_end ? ST_STOP : ST_PARITY;
      ST_STOP: if (bit_end) begin
        if (stp2_q && bit_q == 3'd0) bit_d = 3'd1;
        else begin
          state_d = ST_IDLE;
          bit_d = 3'd0;
          start = go;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_START;
      tick_d = 4'd0;
      bit_d = 3'd0;
      sh_d = fifo_dout;
      wlen_d = WLEN;
      pen_d = PEN;
      eps_d = EPS;
      stp2_d = STP2;
      par_d = EPS ? ^(fifo_dout & wlen_mask(WLEN)) : ~^(fifo_dout & wlen_mask(WLEN));
    end
    if (!En) begin
      state_d = ST_IDLE;
      tick_d = 4'd0;
      bit_d = 3'd0;
    end
    txd_d = BRK ? 1'b0 : state_d == ST_START ? 1'b0 : state_d == ST_DATA ? sh_d[0] :
            state_d == ST_PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      tick_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      wlen_q <= WLEN_8;
      pen_q <= 1'b0;
      eps_q <= 1'b0;
      stp2_q <= 1'b0;
      par_q <= 1'b0;
      txd_q <= 1'b1;
      fen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      wlen_q <= wlen_d;
      pen_q <= pen_d;
      eps_q <= eps_d;
      stp2_q <= stp2_d;
      par_q <= par_d;
      txd_q <= txd_d;
      fen_q <= FEN;
    end
  end
  assign TXD = txd_q;
  assign TxEmpty = empty;
  assign TxFull = full;
  assign Busy = (state_q != ST_IDLE) | ~empty;
endmodule
